// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter: shares one single-port VRAM between the display line
// prefetch engine and a CPU request port, in the pixel clock domain.
// Fetch wins arbitration; a pending CPU request that keeps losing is forced
// a slot once its wait counter reaches MAX_WAIT.
module vram_scan_arbiter #(
   parameter int CORDW      = 11,
   parameter int V_RES      = 600,
   parameter int LINE_WORDS = 128,
   parameter int AW         = 16,
   parameter int DW         = 8,
   parameter int BASE_ADDR  = 0,
   parameter int MAX_WAIT   = 4
) (
   input  logic                          clk_pix,
   input  logic                          rst_pix,
   input  logic                          line,
   input  logic signed [CORDW-1:0]       sy,
   input  logic                          cpu_req,
   input  logic                          cpu_we,
   input  logic [AW-1:0]                 cpu_addr,
   input  logic [DW-1:0]                 cpu_wdata,
   output logic                          cpu_ack,
   output logic [DW-1:0]                 cpu_rdata,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [AW-1:0]                 mem_addr,
   output logic [DW-1:0]                 mem_wdata,
   input  logic [DW-1:0]                 mem_rdata,
   output logic                          lb_we,
   output logic                          lb_sel,
   output logic [$clog2(LINE_WORDS)-1:0] lb_addr,
   output logic [DW-1:0]                 lb_data,
   output logic                          fetch_busy,
   output logic                          underrun
);

   localparam int LWW = $clog2(LINE_WORDS);
   localparam int WCW = $clog2(MAX_WAIT + 1);
   localparam logic [LWW-1:0]          LAST_WORD = LWW'(LINE_WORDS - 1);
   localparam logic [WCW-1:0]          WAIT_MAX  = WCW'(MAX_WAIT);
   localparam logic [AW-1:0]           BASE_A    = AW'(BASE_ADDR);
   localparam logic signed [CORDW:0]   Y_MAX     = (CORDW + 1)'(V_RES - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [LWW-1:0]   word_q, word_d;
   logic [AW-1:0]    base_q, base_d;
   logic             tgt_sel_q, tgt_sel_d;
   logic [WCW-1:0]   wait_q, wait_d;
   logic             underrun_q, underrun_d;
   logic             mem_en_q, mem_en_d;
   logic             mem_we_q, mem_we_d;
   logic [AW-1:0]    mem_addr_q, mem_addr_d;
   logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
   logic             slot_fetch_q, slot_fetch_d;
   logic             slot_cpu_q, slot_cpu_d;
   logic [LWW-1:0]   slot_word_q, slot_word_d;
   logic             slot_sel_q, slot_sel_d;
   logic             lb_we_q, lb_we_d;
   logic [LWW-1:0]   lb_addr_q, lb_addr_d;
   logic             lb_sel_q, lb_sel_d;
   logic             cpu_ack_q, cpu_ack_d;
   logic             cpu_rd_q, cpu_rd_d;

   logic signed [CORDW:0] y_s;
   logic                  y_valid_s;
   logic [AW-1:0]         y_addr_s;
   logic [AW-1:0]         base_line_s;
   logic                  cpu_elig_s;
   logic                  fetch_win_s;

   // Target line is the one after sy; widened by one bit so sy+1 cannot wrap.
   assign y_s         = $signed({sy[CORDW-1], sy}) + $signed({{CORDW{1'b0}}, 1'b1});
   assign y_valid_s   = ~y_s[CORDW] && (y_s <= Y_MAX);
   assign y_addr_s    = AW'(y_s);
   assign base_line_s = BASE_A + (y_addr_s << LWW);

   // The CPU is blocked while its own slot is on the bus and in its ack cycle,
   // so a request still held during the ack is never granted twice.
   assign cpu_elig_s  = cpu_req && !slot_cpu_q && !cpu_ack_q;
   assign fetch_win_s = (state_q == FETCH) && (!cpu_elig_s || (wait_q < WAIT_MAX));

   // Arbitration, fetch sequencing and line-start handling; line overrides only
   // the fetch bookkeeping, the slot itself is decided on pre-line state.
   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      base_d       = base_q;
      tgt_sel_d    = tgt_sel_q;
      wait_d       = wait_q;
      underrun_d   = underrun_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = {AW{1'b0}};
      mem_wdata_d  = {DW{1'b0}};
      slot_fetch_d = 1'b0;
      slot_cpu_d   = 1'b0;
      slot_word_d  = {LWW{1'b0}};
      slot_sel_d   = 1'b0;

      if (fetch_win_s) begin
         mem_en_d     = 1'b1;
         mem_addr_d   = base_q + AW'(word_q);
         slot_fetch_d = 1'b1;
         slot_word_d  = word_q;
         slot_sel_d   = tgt_sel_q;
         if (word_q == LAST_WORD) begin
            state_d = IDLE;
         end else begin
            word_d = word_q + LWW'(1);
         end
         if (cpu_elig_s) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WCW'(1);
         end else begin
            wait_d = {WCW{1'b0}};
         end
      end else if (cpu_elig_s) begin
         mem_en_d    = 1'b1;
         mem_we_d    = cpu_we;
         mem_addr_d  = cpu_addr;
         mem_wdata_d = cpu_wdata;
         slot_cpu_d  = 1'b1;
         wait_d      = {WCW{1'b0}};
      end else begin
         wait_d = {WCW{1'b0}};
      end

      if (line) begin
         // Words still unissued after this cycle's slot are being cut short.
         if (state_d == FETCH) begin
            underrun_d = 1'b1;
         end else begin
            underrun_d = underrun_q;
         end
         if (y_valid_s) begin
            state_d   = FETCH;
            word_d    = {LWW{1'b0}};
            base_d    = base_line_s;
            tgt_sel_d = y_s[0];
         end else begin
            state_d = IDLE;
         end
      end else begin
         underrun_d = underrun_q;
      end
   end

   // Completion stage: the slot on the bus now returns its data next cycle.
   always_comb begin
      lb_we_d   = slot_fetch_q;
      cpu_ack_d = slot_cpu_q;
      cpu_rd_d  = slot_cpu_q && !mem_we_q;
      if (slot_fetch_q) begin
         lb_addr_d = slot_word_q;
         lb_sel_d  = slot_sel_q;
      end else begin
         lb_addr_d = lb_addr_q;
         lb_sel_d  = lb_sel_q;
      end
   end

   // State and output registers; async assert clears everything.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         state_q      <= IDLE;
         word_q       <= {LWW{1'b0}};
         base_q       <= {AW{1'b0}};
         tgt_sel_q    <= 1'b0;
         wait_q       <= {WCW{1'b0}};
         underrun_q   <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= {AW{1'b0}};
         mem_wdata_q  <= {DW{1'b0}};
         slot_fetch_q <= 1'b0;
         slot_cpu_q   <= 1'b0;
         slot_word_q  <= {LWW{1'b0}};
         slot_sel_q   <= 1'b0;
         lb_we_q      <= 1'b0;
         lb_addr_q    <= {LWW{1'b0}};
         lb_sel_q     <= 1'b0;
         cpu_ack_q    <= 1'b0;
         cpu_rd_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         base_q       <= base_d;
         tgt_sel_q    <= tgt_sel_d;
         wait_q       <= wait_d;
         underrun_q   <= underrun_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         slot_fetch_q <= slot_fetch_d;
         slot_cpu_q   <= slot_cpu_d;
         slot_word_q  <= slot_word_d;
         slot_sel_q   <= slot_sel_d;
         lb_we_q      <= lb_we_d;
         lb_addr_q    <= lb_addr_d;
         lb_sel_q     <= lb_sel_d;
         cpu_ack_q    <= cpu_ack_d;
         cpu_rd_q     <= cpu_rd_d;
      end
   end

   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign lb_we      = lb_we_q;
   assign lb_sel     = lb_sel_q;
   assign lb_addr    = lb_addr_q;
   assign lb_data    = lb_we_q ? mem_rdata : {DW{1'b0}};
   assign cpu_ack    = cpu_ack_q;
   assign cpu_rdata  = cpu_rd_q ? mem_rdata : {DW{1'b0}};
   assign fetch_busy = (state_q == FETCH);
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Bench for vram_scan_arbiter: directed scenarios followed by random line and
// CPU traffic, all checked cycle by cycle against a transaction-level model
// that tracks remaining fetch words, the CPU wait count and a shadow VRAM.
module tb_vram_scan_arbiter;

   localparam int CORDW      = 11;
   localparam int V_RES      = 600;
   localparam int LINE_WORDS = 128;
   localparam int AW         = 16;
   localparam int DW         = 8;
   localparam int BASE_ADDR  = 'h1000;
   localparam int MAX_WAIT   = 4;

   logic             clk_pix = 1'b0;
   logic             rst_pix = 1'b1;
   logic             line = 1'b0;
   logic [CORDW-1:0] sy = '0;
   logic             cpu_req = 1'b0;
   logic             cpu_we = 1'b0;
   logic [AW-1:0]    cpu_addr = '0;
   logic [DW-1:0]    cpu_wdata = '0;
   logic             cpu_ack;
   logic [DW-1:0]    cpu_rdata;
   logic             mem_en;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [DW-1:0]    mem_wdata;
   logic [DW-1:0]    mem_rdata = '0;
   logic             lb_we;
   logic             lb_sel;
   logic [6:0]       lb_addr;
   logic [DW-1:0]    lb_data;
   logic             fetch_busy;
   logic             underrun;

   vram_scan_arbiter #(
      .CORDW(CORDW), .V_RES(V_RES), .LINE_WORDS(LINE_WORDS), .AW(AW),
      .DW(DW), .BASE_ADDR(BASE_ADDR), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk_pix(clk_pix), .rst_pix(rst_pix), .line(line), .sy(sy),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lb_we(lb_we),
      .lb_sel(lb_sel), .lb_addr(lb_addr), .lb_data(lb_data),
      .fetch_busy(fetch_busy), .underrun(underrun)
   );

   always #5 clk_pix = ~clk_pix;

   function automatic logic [7:0] init_byte(int a);
      return 8'((a * 37) ^ (a >>> 8) ^ 'h5C);
   endfunction

   // VRAM environment: one-cycle read latency, writes on the slot edge.
   logic [7:0] vram [0:65535];
   initial begin
      for (int i = 0; i < 65536; i++) vram[i] = init_byte(i);
      forever begin
         @(posedge clk_pix);
         if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) vram[mem_addr] = mem_wdata;
            else mem_rdata <= vram[mem_addr];
         end
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state.
   logic [7:0] shadow [0:65535];
   int m_left, m_word, m_y, m_wait, m_block, m_under;
   int e_mem_en, e_mem_we, e_mem_addr, e_mem_wdata, e_slot_fetch, e_slot_cpu;
   int e_slot_word, e_slot_sel, e_lb_we, e_lb_addr, e_lb_sel, e_lb_data;
   int e_ack, e_rd, e_rdata;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_left = 0; m_word = 0; m_y = 0; m_wait = 0; m_block = 0; m_under = 0;
      e_mem_en = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0;
      e_slot_fetch = 0; e_slot_cpu = 0; e_slot_word = 0; e_slot_sel = 0;
      e_lb_we = 0; e_lb_addr = 0; e_lb_sel = 0; e_lb_data = 0;
      e_ack = 0; e_rd = 0; e_rdata = 0;
   endtask

   // Advance one clock: model predicts the next cycle from this cycle's inputs.
   task automatic step();
      int n_lb_we, n_lb_addr, n_lb_sel, n_lb_data, n_ack, n_rd, n_rdata;
      int n_en, n_we, n_addr, n_wdata, n_fetch, n_cpu, n_word, n_sel, y;
      bit elig;
      n_lb_we = e_mem_en & e_slot_fetch;
      n_lb_addr = e_lb_addr; n_lb_sel = e_lb_sel; n_lb_data = 0;
      if (n_lb_we != 0) begin
         n_lb_addr = e_slot_word; n_lb_sel = e_slot_sel;
         n_lb_data = int'(shadow[e_mem_addr]);
      end
      n_ack = e_mem_en & e_slot_cpu;
      n_rd = n_ack & (e_mem_we == 0 ? 1 : 0);
      n_rdata = (n_rd != 0) ? int'(shadow[e_mem_addr]) : 0;
      if (n_ack != 0 && e_mem_we != 0) shadow[e_mem_addr] = 8'(e_mem_wdata);

      elig = (cpu_req === 1'b1) && (m_block == 0);
      n_en = 0; n_we = 0; n_addr = 0; n_wdata = 0; n_fetch = 0; n_cpu = 0;
      n_word = 0; n_sel = 0;
      if (m_left > 0 && (!elig || m_wait < MAX_WAIT)) begin
         n_en = 1; n_fetch = 1;
         n_addr = (BASE_ADDR + m_y * LINE_WORDS + m_word) & 'hFFFF;
         n_word = m_word; n_sel = m_y & 1;
         m_word++; m_left--;
         m_wait = elig ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
      end else if (elig) begin
         n_en = 1; n_cpu = 1; n_we = int'(cpu_we); n_addr = int'(cpu_addr);
         n_wdata = int'(cpu_wdata); m_wait = 0;
      end else begin
         m_wait = 0;
      end
      if (n_cpu != 0) m_block = 2;
      else if (m_block > 0) m_block--;

      if (line === 1'b1) begin
         if (m_left > 0) m_under = 1;
         y = int'($signed(sy)) + 1;
         if (y >= 0 && y < V_RES) begin
            m_left = LINE_WORDS; m_word = 0; m_y = y;
         end else begin
            m_left = 0;
         end
      end

      @(posedge clk_pix);
      #1;
      e_mem_en = n_en; e_mem_we = n_we; e_mem_addr = n_addr; e_mem_wdata = n_wdata;
      e_slot_fetch = n_fetch; e_slot_cpu = n_cpu; e_slot_word = n_word; e_slot_sel = n_sel;
      e_lb_we = n_lb_we; e_lb_addr = n_lb_addr; e_lb_sel = n_lb_sel; e_lb_data = n_lb_data;
      e_ack = n_ack; e_rd = n_rd; e_rdata = n_rdata;

      chk("mem_en", 32'(mem_en), 32'(e_mem_en));
      if (e_mem_en != 0) begin
         chk("mem_we", 32'(mem_we), 32'(e_mem_we));
         chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
         if (e_mem_we != 0) chk("mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
      end
      chk("lb_we", 32'(lb_we), 32'(e_lb_we));
      if (e_lb_we != 0) begin
         chk("lb_addr", 32'(lb_addr), 32'(e_lb_addr));
         chk("lb_sel", 32'(lb_sel), 32'(e_lb_sel));
         chk("lb_data", 32'(lb_data), 32'(e_lb_data));
      end
      chk("cpu_ack", 32'(cpu_ack), 32'(e_ack));
      if (e_rd != 0) chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
      chk("fetch_busy", 32'(fetch_busy), 32'(m_left > 0 ? 1 : 0));
      chk("underrun", 32'(underrun), 32'(m_under));
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_line(int s);
      sy = CORDW'(s);
      line = 1'b1;
      step();
      line = 1'b0;
   endtask

   // Assert reset asynchronously mid-cycle, check outputs, release after an edge.
   task automatic do_reset();
      rst_pix = 1'b1;
      cpu_req = 1'b0;
      line = 1'b0;
      #1;
      chk("rst_mem_en", 32'(mem_en), 32'(0));
      chk("rst_mem_we", 32'(mem_we), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr), 32'(0));
      chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
      chk("rst_lb_we", 32'(lb_we), 32'(0));
      chk("rst_lb_sel", 32'(lb_sel), 32'(0));
      chk("rst_lb_addr", 32'(lb_addr), 32'(0));
      chk("rst_lb_data", 32'(lb_data), 32'(0));
      chk("rst_cpu_ack", 32'(cpu_ack), 32'(0));
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
      chk("rst_fetch_busy", 32'(fetch_busy), 32'(0));
      chk("rst_underrun", 32'(underrun), 32'(0));
      model_reset();
      @(posedge clk_pix);
      #1;
      rst_pix = 1'b0;
   endtask

   initial begin
      int cnt_en, cnt_lb, cnt_we, cnt_ack, ack_at, gap, sel, sv;
      bit ack_seen;
      for (int i = 0; i < 65536; i++) shadow[i] = init_byte(i);
      model_reset();
      do_reset();

      // Full line fetch for target line 0, no CPU traffic.
      pulse_line(-1);
      cnt_en = 0; cnt_lb = 0;
      for (int i = 0; i < 135; i++) begin
         step();
         if (mem_en === 1'b1) cnt_en++;
         if (lb_we === 1'b1) cnt_lb++;
      end
      chk("line0_slots", 32'(cnt_en), 32'(128));
      chk("line0_lb_writes", 32'(cnt_lb), 32'(128));
      chk("line0_busy_end", 32'(fetch_busy), 32'(0));

      // Target line 5: base 0x1000 + 5*128, odd buffer half.
      pulse_line(4);
      chk("sy4_no_slot_yet", 32'(mem_en), 32'(0));
      step();
      chk("sy4_first_addr", 32'(mem_addr), 32'('h1280));
      chk("sy4_busy", 32'(fetch_busy), 32'(1));
      step();
      chk("sy4_lb_sel", 32'(lb_sel), 32'(1));
      chk("sy4_lb_addr", 32'(lb_addr), 32'(0));
      run(130);

      // Last active line: nothing to prefetch.
      pulse_line(V_RES - 1);
      cnt_en = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (mem_en === 1'b1) cnt_en++;
      end
      chk("sy599_slots", 32'(cnt_en), 32'(0));
      chk("sy599_busy", 32'(fetch_busy), 32'(0));

      // CPU read contending with fetch: forced through after MAX_WAIT losses.
      pulse_line(-1);
      run(5);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042;
      run(MAX_WAIT + 1);
      chk("cpu_rd_slot_en", 32'(mem_en), 32'(1));
      chk("cpu_rd_slot_addr", 32'(mem_addr), 32'('h42));
      step();
      chk("cpu_rd_ack", 32'(cpu_ack), 32'(1));
      chk("cpu_rd_data", 32'(cpu_rdata), 32'(init_byte('h42)));
      cpu_req = 1'b0;
      run(140);

      // CPU write while idle, request still high during the ack cycle.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'h5A;
      cnt_we = 0; cnt_ack = 0; ack_at = -1; ack_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (ack_seen) cpu_req = 1'b0;
         step();
         if (i == 0) chk("cpu_wr_data", 32'(mem_wdata), 32'('h5A));
         if (mem_en === 1'b1 && mem_we === 1'b1) cnt_we++;
         if (cpu_ack === 1'b1) begin
            cnt_ack++; ack_at = i; ack_seen = 1'b1;
         end
      end
      chk("cpu_wr_slots", 32'(cnt_we), 32'(1));
      chk("cpu_wr_acks", 32'(cnt_ack), 32'(1));
      chk("cpu_wr_ack_at", 32'(ack_at), 32'(1));
      cpu_req = 1'b0;

      // Underrun: new line arrives while word 59 of line 10 is being issued.
      pulse_line(9);
      run(59);
      chk("ur_word58_addr", 32'(mem_addr), 32'('h1000 + 10 * 128 + 58));
      pulse_line(20);
      chk("ur_word59_addr", 32'(mem_addr), 32'('h1000 + 10 * 128 + 59));
      chk("ur_flag", 32'(underrun), 32'(1));
      step();
      chk("ur_old_lb_addr", 32'(lb_addr), 32'(59));
      chk("ur_old_lb_sel", 32'(lb_sel), 32'(0));
      chk("ur_new_first_addr", 32'(mem_addr), 32'('h1000 + 21 * 128));
      run(140);

      // Reset in the middle of a fetch, then quiet until the next line.
      pulse_line(-1);
      run(41);
      chk("mid_word40", 32'(mem_addr), 32'('h1000 + 40));
      do_reset();
      cnt_lb = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (lb_we === 1'b1) cnt_lb++;
      end
      chk("post_rst_lb_we", 32'(cnt_lb), 32'(0));

      // Random line timing and CPU traffic.
      gap = 3; ack_seen = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if (gap == 0) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) sv = V_RES - 1;
            else if (sel == 1) sv = -1 - $urandom_range(0, 4);
            else if (sel == 2) sv = V_RES + $urandom_range(0, 400);
            else sv = $urandom_range(0, V_RES - 2);
            sy = CORDW'(sv);
            line = 1'b1;
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 127) : $urandom_range(130, 220);
         end else begin
            line = 1'b0;
            gap--;
         end
         if (cpu_req) begin
            if (ack_seen) begin
               cpu_req = 1'b0; ack_seen = 1'b0;
            end else if (e_ack != 0) begin
               ack_seen = 1'b1;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            cpu_req = 1'b1;
            cpu_we = 1'($urandom);
            cpu_addr = 16'($urandom);
            cpu_wdata = 8'($urandom);
         end
         step();
      end
      line = 1'b0;
      cpu_req = 1'b0;
      run(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vram_scan_arbiter.md
Name: vram_scan_arbiter

Overview:
- Shares one single-port VRAM between two users: the display line-prefetch engine and a CPU-side request port.
- Runs in the pixel clock domain and is driven by the `line` pulse and `sy` output of the display timing generator.
- On each line start it prefetches the next active line into a double-buffered line buffer (`lb_sel` = target line parity).
- Fetch has priority over the CPU, except that a starvation guard forces a CPU slot after MAX_WAIT lost cycles.

Parameters:
- CORDW, 11: signed width of `sy`.
- V_RES, 600: active lines.
- LINE_WORDS, 128: VRAM words fetched per line (power of 2).
- AW, 16: VRAM address width.
- DW, 8: VRAM data width.
- BASE_ADDR, 0: VRAM address of line 0, word 0.
- MAX_WAIT, 4: consecutive cycles a pending CPU request may lose before it is forced a slot (≥1).

Ports:
- clk_pix  in  1  pixel clock
- rst_pix  in  1  asynchronous active-high reset
- line  in  1  start-of-line pulse from display timing
- sy  in  CORDW  signed current line, valid with `line`
- cpu_req  in  1  CPU request; held stable until `cpu_ack`
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data, valid while `cpu_ack` = 1 for a read
- mem_en  out  1  VRAM access this cycle (a "slot")
- mem_we  out  1  VRAM write enable
- mem_addr  out  AW  VRAM address
- mem_wdata  out  DW  VRAM write data
- mem_rdata  in  DW  VRAM read data, valid the cycle after a read slot
- lb_we  out  1  line-buffer write strobe
- lb_sel  out  1  line-buffer half (target line bit 0)
- lb_addr  out  log2(LINE_WORDS)  line-buffer word index
- lb_data  out  DW  line-buffer write data (= mem_rdata)
- fetch_busy  out  1  words of current line still unissued
- underrun  out  1  sticky: a fetch was cut short by `line`

Behaviour:
- Reset (async assert, sync release): every output 0; state IDLE; wait counter 0; no tags in flight.
- `mem_*` are registered. A slot is any cycle t with mem_en = 1.
- Data for a read slot in cycle t is presented in cycle t+1:
  - fetch read: lb_we = 1, with lb_addr/lb_sel taken from the tag latched at issue;
  - CPU access (read or write): cpu_ack = 1, and cpu_rdata = mem_rdata for a read.
- mem_we is 1 only for CPU write slots; fetch slots are always reads.
- Line start, `line` = 1 in cycle t:
  - Target line y = sy + 1.
  - If 0 ≤ y ≤ V_RES−1: load word index 0, latch base address BASE_ADDR + y·LINE_WORDS (mod 2^AW), set lb_sel = y[0], enter FETCH. The first fetch slot is eligible in t+1.
  - Otherwise (y out of range, including sy = V_RES−1): no fetch, and any unissued words are dropped.
- States:
  - IDLE: fetch_busy = 0.
  - FETCH: fetch_busy = 1; word index advances by 1 per fetch slot; after issuing word LINE_WORDS−1, go to IDLE.
- Arbitration each cycle:
  - CPU is eligible if cpu_req = 1 and no CPU access was granted in the previous cycle (the ack cycle is never re-granted).
  - If FETCH and (CPU not eligible or wait_cnt < MAX_WAIT): fetch slot. If CPU is eligible, wait_cnt += 1, saturating.
  - Else if CPU is eligible: CPU slot; wait_cnt ← 0.
  - Else: no slot (mem_en = 0).
  - wait_cnt ← 0 whenever CPU is not eligible.
- `line` while in FETCH with words unissued: underrun ← 1 until reset, and the fetch restarts per the line-start rule. Reads already issued still complete with their original tag.
- `line` and a slot decision in the same cycle: the slot uses the pre-`line` state.
- Worst-case CPU latency under fetch: MAX_WAIT+1 cycles from eligibility to slot, ack one cycle later.

Test Plan:
- Reset mid-FETCH (word 40 issued) -> all outputs 0 immediately; no lb_we after release until the next `line`.
- `line`, sy = −1, no CPU traffic -> mem_addr 0..127 on 128 consecutive cycles starting t+1; lb_we with lb_sel = 0, lb_addr 0..127 one cycle later; fetch_busy falls after the slot with address 127.
- `line`, sy = 4, BASE_ADDR = 0x1000 -> first mem_addr = 0x1280, lb_sel = 1; sy = 599 -> no slots, fetch_busy stays 0.
- CPU read at 0x0042 during FETCH, MAX_WAIT = 4 -> 4 fetch slots, then CPU slot on the 5th eligible cycle, cpu_ack + cpu_rdata = VRAM[0x42] the next cycle; fetch resumes without skipping a word.
- CPU write in IDLE, cpu_req held one extra cycle -> exactly one mem_we slot, cpu_ack one cycle later, no second grant.
- Second `line` after 60 words issued -> underrun = 1; word 59 still written to the old lb_sel; new fetch starts at word 0 of line sy+1.
